// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative WIDTH-bit multiply/divide unit. It performs one shift-add
// (multiply) or one restoring shift-subtract (divide) step per clock. Both
// sides use valid/ready handshakes. The unit is not pipelined: each operation
// takes WIDTH+2 cycles from accept to out_valid.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operands and op are valid
//   in_ready   unit can accept a new operation (state is IDLE)
//   op         00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a          multiplicand / dividend
//   b          multiplier / divisor
//   out_valid  result is valid (state is DONE)
//   out_ready  consumer accepts the result
//   res_hi     MUL: upper product half, DIV: remainder
//   res_lo     MUL: lower product half, DIV: quotient
//   div0       result came from a divide by zero
//   ovf        result came from the signed divide overflow case
//   busy       state is not IDLE
// -----------------------------------------------------------------------------
module muldiv_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div0,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [1:0]       OP_DIVS   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

   state_e             state_q,      state_d;
   logic [1:0]         op_q,         op_d;
   logic [WIDTH-1:0]   opd_q,        opd_d;      // multiplicand (MUL) or divisor (DIV) magnitude
   logic [2*WIDTH-1:0] acc_q,        acc_d;      // MUL: {hi, lo} product, DIV: {rem, quo}
   logic [CW-1:0]      cnt_q,        cnt_d;
   logic               neg_res_q,    neg_res_d;  // negate product / quotient in FIX
   logic               neg_rem_q,    neg_rem_d;  // negate remainder in FIX
   logic               ovf_case_q,   ovf_case_d;
   logic [WIDTH-1:0]   a_raw_q,      a_raw_d;    // dividend as given, returned on divide by zero
   logic [WIDTH-1:0]   res_hi_q,     res_hi_d;
   logic [WIDTH-1:0]   res_lo_q,     res_lo_d;
   logic               div0_q,       div0_d;
   logic               ovf_q,        ovf_d;

   // Operand magnitudes. -2^(W-1) negates to itself, which read as unsigned
   // is exactly 2^(W-1), so no extra bit is needed.
   logic [WIDTH-1:0] a_mag, b_mag;
   assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
   assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

   // One multiply step: conditional add into the upper half, carry kept, then
   // the whole 2W-bit accumulator shifts right by one.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_step;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
   assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

   // One restoring divide step. The shifted remainder is W+1 bits; as the
   // remainder stays below the divisor, bit W of the W+1-bit difference is a
   // reliable borrow flag.
   logic [WIDTH:0]       div_trial;
   logic                 div_ok;
   logic [2*WIDTH-1:0]   div_step;
   assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
   assign div_ok    = ~div_trial[WIDTH];
   assign div_step  = {(div_ok ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                       acc_q[WIDTH-2:0], div_ok};

   // Sign fix-up of the unsigned results.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = neg_res_q ? -acc_q : acc_q;
   assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      // NOTE: every next-state variable takes its held value first, so no
      // branch below can leave one unassigned and infer a latch.
      state_d    = state_q;
      op_d       = op_q;
      opd_d      = opd_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      ovf_case_d = ovf_case_q;
      a_raw_d    = a_raw_q;
      res_hi_d   = res_hi_q;
      res_lo_d   = res_lo_q;
      div0_d     = div0_q;
      ovf_d      = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d       = op;
               // MUL: multiplier sits in the low half and is consumed LSB first.
               // DIV: dividend sits in the low half and is shifted out MSB first.
               opd_d      = op[1] ? b_mag : a_mag;
               acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
               cnt_d      = '0;
               neg_res_d  = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d  = op[0] & a[WIDTH-1];
               ovf_case_d = (op == OP_DIVS) && (a == MIN_NEG) && (b == '1);
               a_raw_d    = a;
               div0_d     = 1'b0;
               ovf_d      = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            acc_d = op_q[1] ? div_step : mul_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (!op_q[1]) begin
               {res_hi_d, res_lo_d} = prod_fix;
            end else if (opd_q == '0) begin
               // Divide by zero: fixed result regardless of signedness.
               res_hi_d = a_raw_q;
               res_lo_d = '1;
               div0_d   = 1'b1;
            end else begin
               // The overflow case falls out of the magnitude path: 2^(W-1)/1
               // with equal signs gives MIN_NEG and remainder 0.
               res_hi_d = rem_fix;
               res_lo_d = quo_fix;
               ovf_d    = ovf_case_q;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         opd_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         ovf_case_q <= 1'b0;
         a_raw_q    <= '0;
         res_hi_q   <= '0;
         res_lo_q   <= '0;
         div0_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         opd_q      <= opd_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         ovf_case_q <= ovf_case_d;
         a_raw_q    <= a_raw_d;
         res_hi_q   <= res_hi_d;
         res_lo_q   <= res_lo_d;
         div0_q     <= div0_d;
         ovf_q      <= ovf_d;
      end
   end

   // All outputs come straight from registers.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res_hi    = res_hi_q;
   assign res_lo    = res_lo_q;
   assign div0      = div0_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//
// Drives a WIDTH=8 and a WIDTH=16 instance of muldiv_seq from one shared
// stimulus bus; sel picks which instance sees the handshakes and whose outputs
// are observed. Expected values come from directed constants or from an
// integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        in_valid;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic        out_ready;

   logic        in_ready8, out_valid8, div0_8, ovf8, busy8;
   logic [7:0]  res_hi8, res_lo8;
   logic        in_ready16, out_valid16, div0_16, ovf16, busy16;
   logic [15:0] res_hi16, res_lo16;

   logic        in_ready_m, out_valid_m, div0_m, ovf_m, busy_m;
   logic [15:0] res_hi_m, res_lo_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid & ~sel),
      .in_ready  (in_ready8),
      .op        (op),
      .a         (a[7:0]),
      .b         (b[7:0]),
      .out_valid (out_valid8),
      .out_ready (out_ready & ~sel),
      .res_hi    (res_hi8),
      .res_lo    (res_lo8),
      .div0      (div0_8),
      .ovf       (ovf8),
      .busy      (busy8)
   );

   muldiv_seq #(.WIDTH(16)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid & sel),
      .in_ready  (in_ready16),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid16),
      .out_ready (out_ready & sel),
      .res_hi    (res_hi16),
      .res_lo    (res_lo16),
      .div0      (div0_16),
      .ovf       (ovf16),
      .busy      (busy16)
   );

   assign in_ready_m  = sel ? in_ready16  : in_ready8;
   assign out_valid_m = sel ? out_valid16 : out_valid8;
   assign div0_m      = sel ? div0_16     : div0_8;
   assign ovf_m       = sel ? ovf16       : ovf8;
   assign busy_m      = sel ? busy16      : busy8;
   assign res_hi_m    = sel ? res_hi16    : {8'h00, res_hi8};
   assign res_lo_m    = sel ? res_lo16    : {8'h00, res_lo8};

   // Reference model: plain integer arithmetic on w-bit two's-complement values.
   function automatic void model(input int w, input logic [1:0] o,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 output logic [15:0] hi, output logic [15:0] lo,
                                 output logic d0, output logic ov);
      longint mask = (longint'(1) << w) - 1;
      longint half = longint'(1) << (w - 1);
      longint ua = longint'(av) & mask;
      longint ub = longint'(bv) & mask;
      longint sa = (ua >= half) ? ua - (mask + 1) : ua;
      longint sb = (ub >= half) ? ub - (mask + 1) : ub;
      longint x, y, p, q, r;
      x  = o[0] ? sa : ua;
      y  = o[0] ? sb : ub;
      d0 = 1'b0;
      ov = 1'b0;
      if (!o[1]) begin
         p  = x * y;
         lo = 16'(p & mask);
         hi = 16'((p >> w) & mask);
      end else if (ub == 0) begin
         lo = 16'(mask);
         hi = 16'(ua);
         d0 = 1'b1;
      end else if (o[0] && sa == -half && sb == -1) begin
         lo = 16'(ua);
         hi = 16'h0000;
         ov = 1'b1;
      end else begin
         q  = x / y;  // truncates toward zero
         r  = x % y;  // takes the sign of the dividend
         lo = 16'(q & mask);
         hi = 16'(r & mask);
      end
   endfunction

   // Issue one operation, check latency, result, flags, backpressure and the
   // handshake that returns the unit to IDLE.
   task automatic run_op(input bit s, input logic [1:0] o,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] ehi, input logic [15:0] elo,
                         input logic ed0, input logic eov,
                         input int stall, input string tag);
      int w = s ? 16 : 8;
      int lat = 0;
      int guard = 0;
      sel = s;
      @(negedge clk);
      while (!in_ready_m && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (in_ready_m !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready before issue: got %b want 1", tag, in_ready_m);
      end
      in_valid  = 1'b1;
      op        = o;
      a         = av;
      b         = bv;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      // Operands must only matter on the accept edge.
      in_valid = 1'b0;
      op       = 2'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid_m) begin
            n_checks++;
            if (in_ready_m !== 1'b0 || busy_m !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy phase cycle %0d: in_ready=%b busy=%b want 0/1",
                        tag, lat, in_ready_m, busy_m);
            end
         end
      end while (!out_valid_m && lat < 100);
      n_checks++;
      if (lat != w + 2) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", tag, lat, w + 2);
      end
      n_checks++;
      if (res_hi_m !== ehi || res_lo_m !== elo || div0_m !== ed0 || ovf_m !== eov) begin
         n_fail++;
         $display("FAIL %s result: got hi=%h lo=%h div0=%b ovf=%b want hi=%h lo=%h div0=%b ovf=%b",
                  tag, res_hi_m, res_lo_m, div0_m, ovf_m, ehi, elo, ed0, eov);
      end
      // Backpressure: outputs hold and a pending request is not taken.
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         op       = 2'($urandom);
         a        = 16'($urandom);
         b        = 16'($urandom);
         @(negedge clk);
         n_checks++;
         if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || res_hi_m !== ehi ||
             res_lo_m !== elo || div0_m !== ed0 || ovf_m !== eov) begin
            n_fail++;
            $display("FAIL %s stall %0d: got valid=%b ready=%b hi=%h lo=%h div0=%b ovf=%b want 1/0 hi=%h lo=%h div0=%b ovf=%b",
                     tag, i, out_valid_m, in_ready_m, res_hi_m, res_lo_m, div0_m, ovf_m,
                     ehi, elo, ed0, eov);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || busy_m !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after handshake: valid=%b ready=%b busy=%b want 0/1/0",
                  tag, out_valid_m, in_ready_m, busy_m);
      end
      in_valid = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      n_checks++;
      if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 ||
          res_hi_m !== 16'h0 || res_lo_m !== 16'h0 || div0_m !== 1'b0 || ovf_m !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: ready=%b valid=%b busy=%b hi=%h lo=%h div0=%b ovf=%b want 1/0/0 0 0 0 0",
                  tag, in_ready_m, out_valid_m, busy_m, res_hi_m, res_lo_m, div0_m, ovf_m);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      sel       = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_cleared("reset_w8");
      sel = 1'b1;
      #1;
      check_cleared("reset_w16");
      sel = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_directed_w8();
      run_op(0, 2'b00, 16'd200,  16'd200,  16'h009C, 16'h0040, 0, 0, 0, "mulu_200x200");
      run_op(0, 2'b01, 16'h00FD, 16'h0005, 16'h00FF, 16'h00F1, 0, 0, 0, "muls_m3x5");
      run_op(0, 2'b01, 16'h0080, 16'h0080, 16'h0040, 16'h0000, 0, 0, 0, "muls_min_sq");
      run_op(0, 2'b10, 16'd200,  16'd7,    16'h0004, 16'h001C, 0, 0, 0, "divu_200_7");
      run_op(0, 2'b11, 16'h00F9, 16'h0002, 16'h00FF, 16'h00FD, 0, 0, 0, "divs_m7_2");
      run_op(0, 2'b10, 16'h0005, 16'h0000, 16'h0005, 16'h00FF, 1, 0, 0, "divu_by_zero");
      run_op(0, 2'b11, 16'h00F9, 16'h0000, 16'h00F9, 16'h00FF, 1, 0, 0, "divs_by_zero");
      run_op(0, 2'b11, 16'h0080, 16'h00FF, 16'h0000, 16'h0080, 0, 1, 0, "divs_overflow");
      // A flagged result followed by a MUL: flags must clear on accept.
      run_op(0, 2'b00, 16'h00FF, 16'h00FF, 16'h00FE, 16'h0001, 0, 0, 0, "mulu_max");
   endtask

   task automatic test_backpressure();
      run_op(0, 2'b10, 16'd250, 16'd9, 16'h0007, 16'h001B, 0, 0, 5, "backpressure_divu");
      run_op(1, 2'b00, 16'd300, 16'd300, 16'h0001, 16'h5F90, 0, 0, 5, "backpressure_w16");
   endtask

   task automatic test_reset_mid_op();
      int guard = 0;
      sel = 1'b0;
      @(negedge clk);
      while (!in_ready_m && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      op       = 2'b00;
      a        = 16'd200;
      b        = 16'd200;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_cleared("reset_mid_op");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_cleared("after_reset_release");
      run_op(0, 2'b00, 16'd3, 16'd4, 16'h0000, 16'h000C, 0, 0, 0, "mulu_3x4_after_reset");
   endtask

   task automatic test_directed_w16();
      run_op(1, 2'b00, 16'd200,  16'd200, 16'h0000, 16'h9C40, 0, 0, 0, "w16_mulu_200x200");
      run_op(1, 2'b10, 16'd200,  16'd7,   16'h0004, 16'h001C, 0, 0, 0, "w16_divu_200_7");
      run_op(1, 2'b10, 16'd5,    16'd0,   16'h0005, 16'hFFFF, 1, 0, 0, "w16_divu_by_zero");
      run_op(1, 2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0, 1, 0, "w16_divs_overflow");
   endtask

   task automatic test_random(input bit s, input int n);
      int w = s ? 16 : 8;
      logic [15:0] av, bv, ehi, elo;
      logic [1:0]  o;
      logic        ed0, eov;
      int          pick;
      for (int i = 0; i < n; i++) begin
         o    = 2'($urandom);
         av   = 16'($urandom);
         bv   = 16'($urandom);
         pick = $urandom_range(0, 7);
         if (pick == 0) bv = 16'h0000;
         if (pick == 1) begin
            av = 16'(16'h1 << (w - 1));
            bv = 16'hFFFF;
         end
         if (!s) begin
            av[15:8] = 8'h00;
            bv[15:8] = 8'h00;
         end
         model(w, o, av, bv, ehi, elo, ed0, eov);
         run_op(s, o, av, bv, ehi, elo, ed0, eov, $urandom_range(0, 2),
                s ? "rand_w16" : "rand_w8");
      end
   endtask

   initial begin
      test_reset();
      test_directed_w8();
      test_backpressure();
      test_reset_mid_op();
      test_directed_w16();
      test_random(0, 40);
      test_random(1, 20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
